// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the instruction-fetch (IF)
// and data-memory (DM) ports: DM has priority, IF is forced through after STARVE_MAX denials.
module unified_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_r;
    logic          force_if_s;

    // Grant selection and RAM request mux; an idle cycle parks address/data at zero.
    always_comb begin
        force_if_s = (starve_cnt_r == STARVE_LIMIT);
        if_gnt     = if_req & (~dm_req | force_if_s);
        dm_gnt     = dm_req & ~if_gnt;
        mem_en     = if_gnt | dm_gnt;
        mem_we     = dm_gnt & dm_we;
        if (if_gnt) begin
            mem_addr  = if_addr;
            mem_wdata = {DW{1'b0}};
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else begin
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    // Read data is shared; each port qualifies it with its own rvalid.
    always_comb begin
        if_rdata = mem_rdata;
        dm_rdata = mem_rdata;
    end

    // Consecutive-denial counter for IF; any grant or dropped request clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (if_req && !if_gnt) begin
            if (starve_cnt_r != STARVE_LIMIT) begin
                starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CW{1'b0}};
        end
    end

    // Response tracking: a read granted while rst is high never reports valid data.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
        end else begin
            if_rvalid <= if_gnt;
            dm_rvalid <= dm_gnt & ~dm_we;
        end
    end

    unified_mem_arbiter_chk #(
        .CW         (CW),
        .STARVE_MAX (STARVE_MAX)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .if_gnt     (if_gnt),
        .dm_gnt     (dm_gnt),
        .if_rvalid  (if_rvalid),
        .dm_rvalid  (dm_rvalid),
        .starve_cnt (starve_cnt_r)
    );

endmodule

// Structural invariants of the arbiter, kept apart from the datapath.
module unified_mem_arbiter_chk #(
    parameter int CW         = 3,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          if_gnt,
    input logic          dm_gnt,
    input logic          if_rvalid,
    input logic          dm_rvalid,
    input logic [CW-1:0] starve_cnt
);

    a_one_grant: assert property (@(posedge clk) !(if_gnt && dm_gnt));
    a_one_rvalid: assert property (@(posedge clk) !(if_rvalid && dm_rvalid));
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (starve_cnt <= CW'(STARVE_MAX)));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: behavioural RAM, grant/starvation model
// and a read-response scoreboard checked with immediate assertions.
module tb_unified_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM driven only by the DUT's memory port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_starve = 0;
    bit            exp_if_rv = 1'b0;
    bit            exp_dm_rv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check last cycle's responses, drive inputs, check grants, advance model.
    task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia,
                        input bit dr, input bit dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd, output bit if_gnt_obs);
        bit            e_if, e_dm, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        rsp_t          rs;
        @(negedge clk);
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, exp_if_rv});
        chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, exp_dm_rv});
        chk("starve_cnt", 32'(dut.starve_cnt_r), 32'(m_starve));
        if (exp_if_rv || exp_dm_rv) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                rs = sb.pop_front();
                if (rs.is_dm) chk("dm_rdata", dm_rdata, rs.data);
                else          chk("if_rdata", if_rdata, rs.data);
            end
        end
        rst = r; if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        #1;
        e_if   = ir && (!dr || (m_starve == SM));
        e_dm   = dr && !e_if;
        e_en   = e_if || e_dm;
        e_we   = e_dm && dw;
        e_addr = e_if ? ia : (e_dm ? da : 10'd0);
        e_wd   = e_dm ? dd : 32'd0;
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_if});
        chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, e_dm});
        chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", mem_wdata, e_wd);
        if_gnt_obs = if_gnt;
        exp_if_rv = e_if && !r;
        exp_dm_rv = e_dm && !dw && !r;
        if (exp_if_rv) sb.push_back('{1'b0, shadow[ia]});
        if (exp_dm_rv) sb.push_back('{1'b1, shadow[da]});
        if (e_we) shadow[da] = dd;
        if (r)                  m_starve = 0;
        else if (ir && !e_if)   m_starve = (m_starve == SM) ? SM : m_starve + 1;
        else                    m_starve = 0;
    endtask

    initial begin
        bit g;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = 32'h1000_0000 + (i * 32'h0001_0003);
            shadow[i] = 32'h1000_0000 + (i * 32'h0001_0003);
        end
        ram[4]    = 32'h0050_0093;
        shadow[4] = 32'h0050_0093;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset with no traffic, then release
        step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        step(1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);

        // 1: IF alone
        step(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 10'h0, 32'h0, g);
        chk("t1_if_gnt", {31'd0, g}, 32'd1);
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);

        // 2: DM write then read back
        step(1'b0, 1'b0, 10'h0, 1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF, g);
        step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 10'h010, 32'h0, g);
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        chk("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);

        // 3: sustained contention, IF forced through every fifth cycle
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 10'(8 + i), 1'b1, 1'b0, 10'(40 + i), 32'h0, g);
            chk("t3_pattern", {31'd0, g}, (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);

        // 4: back-to-back alternating IF/DM reads
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 10'h0, 32'h0, g);
            else            step(1'b0, 1'b0, 10'h0, 1'b1, 1'b0, 10'h020, 32'h0, g);
        end
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);

        // 5: build up starvation, then reset in the cycle of a DM read grant
        step(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h030, 32'h0, g);
        step(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h031, 32'h0, g);
        step(1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 10'h032, 32'h0, g);
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        chk("t5_starve_zero", 32'(dut.starve_cnt_r), 32'd0);

        // 6: idle, then drain
        step(1'b0, 1'b0, 10'h3FF, 1'b0, 1'b1, 10'h3FF, 32'hFFFF_FFFF, g);
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        step(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0, g);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
